// File: rtl/lifo_stack_pkg.sv
// Shared definitions for the LIFO stack: operation encodings, default sizing and op decode.
package lifo_stack_pkg;

  localparam int DEF_W      = 8;
  localparam int DEF_AW     = 4;
  localparam int DEF_AF_LVL = 14;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_REPL = 2'd3
  } op_e;

  // PUSH+POP on an empty stack degenerates to a plain push (no underflow).
  function automatic op_e decode_op(input logic push, input logic pop, input logic empty);
    if (push && pop) return empty ? OP_PUSH : OP_REPL;
    if (push)        return OP_PUSH;
    if (pop)         return OP_POP;
    return OP_NONE;
  endfunction

endpackage

// File: rtl/lifo_stack_ram.sv
// Stack storage: one synchronous write port, one asynchronous read port for the below-top prefetch.
module lifo_stack_ram #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [1<<AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack.sv
// Synchronous LIFO with cached top-of-stack, occupancy count, almost-full and sticky error flags.
module lifo_stack
  import lifo_stack_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int AW     = DEF_AW,
  parameter int AF_LVL = DEF_AF_LVL
) (
  input  logic          CLK,
  input  logic          INIT,
  input  logic          PUSH,
  input  logic          POP,
  input  logic [W-1:0]  DI,
  input  logic          CLR_ERR,
  output logic [W-1:0]  DQ,
  output logic [AW:0]   COUNT,
  output logic          EMPTY,
  output logic          FULL,
  output logic          AFULL,
  output logic          OVF,
  output logic          UDF
);

  logic [AW:0]   cnt;
  logic [W-1:0]  top_q;
  logic [W-1:0]  below;
  logic          ovf_q, udf_q;
  op_e           op;
  logic          we;
  logic [AW-1:0] waddr, raddr;
  logic          ovf_ev, udf_ev;

  // Extra pointer bit keeps FULL and EMPTY distinct.
  assign EMPTY = (cnt == '0);
  assign FULL  = cnt[AW];
  assign AFULL = (cnt >= (AW+1)'(AF_LVL));
  assign COUNT = cnt;
  assign DQ    = top_q;
  assign OVF   = ovf_q;
  assign UDF   = udf_q;

  always_comb begin
    op     = decode_op(PUSH, POP, EMPTY);
    ovf_ev = (op == OP_PUSH) && FULL;
    udf_ev = (op == OP_POP) && EMPTY;
    we     = ((op == OP_PUSH) && !FULL) || (op == OP_REPL);
    waddr  = (op == OP_REPL) ? cnt[AW-1:0] - AW'(1) : cnt[AW-1:0];
    // Entry below the current top, ready for a pop on the very next edge.
    raddr  = cnt[AW-1:0] - AW'(2);
  end

  lifo_stack_ram #(.W(W), .AW(AW)) u_ram (
    .clk   (CLK),
    .we    (we),
    .waddr (waddr),
    .wdata (DI),
    .raddr (raddr),
    .rdata (below)
  );

  always_ff @(posedge CLK) begin
    if (INIT) begin
      cnt   <= '0;
      top_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      case (op)
        OP_PUSH: if (!FULL) begin
          cnt   <= cnt + 1'b1;
          top_q <= DI;
        end
        OP_POP: if (!EMPTY) begin
          cnt   <= cnt - 1'b1;
          top_q <= (cnt == (AW+1)'(1)) ? '0 : below;
        end
        OP_REPL: top_q <= DI;
        default: ;
      endcase
      ovf_q <= (ovf_q & ~CLR_ERR) | ovf_ev;
      udf_q <= (udf_q & ~CLR_ERR) | udf_ev;
    end
  end

endmodule
